load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the RISC-V32I core's memory stage and the zero-delay word RAM. It turns byte, halfword and word loads/stores (RV32I funct3 encoding) into word-aligned RAM accesses. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. Accesses that cross a word boundary are either split into two word accesses or faulted.

## Interface
Parameters:
- dataW, 32, data word width; only 32 is supported.
- RAMAddrSize, 32, byte-address width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- LSUReq  in  1  request strobe; accepted only when LSUReady=1.
- LSUWrite  in  1  1 = store, 0 = load.
- LSUFunct3  in  3  LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- LSUAddr  in  RAMAddrSize  byte address.
- LSUWData  in  dataW  store data, taken from the low bytes.
- LSUReady  out  1  high in IDLE only.
- LSUDone  out  1  one-cycle completion pulse.
- LSUFault  out  1  valid with LSUDone.
- LSURData  out  dataW  load result, held until the next LSUDone.
- RAMAddr  out  RAMAddrSize  word-aligned address (bits [1:0]=0).
- RAMDataIn  out  dataW  write data to RAM.
- RAMWriteControl  out  1  RAM write enable.
- RAMOut  in  dataW  combinational RAM read data.

## Operation
- **Accept:** an accept happens when LSUReq && LSUReady. Addr, data, funct3 and write are registered. Requests while busy are ignored, not queued.
- **Terms:**
  - off = addr[1:0].
  - size = 1, 2 or 4 bytes.
  - cross = off+size > 4.
  - word0 = addr & ~3; word1 = word0+4, wrapping modulo 2^RAMAddrSize.
  - Byte order is little-endian.
- **Invalid funct3:** load 011/110/111, or store funct3 > 010. Goes straight to DONE with LSUFault=1. No RAM write; LSURData = 0.
- **FSM states:** IDLE, RD0, RD1, WR0, WR1, DONE.
  - IDLE → on accept: aligned SW → WR0; fault → DONE; else → RD0.
  - RD0: RAMAddr=word0; RAMOut latched into buf0. Next: cross → RD1, else write → WR0, else → DONE.
  - RD1: RAMAddr=word1; RAMOut latched into buf1. Next: write → WR0, else → DONE.
  - WR0: RAMAddr=word0, RAMWriteControl=1, RAMDataIn = buf0 with the addressed bytes replaced. Next: cross → WR1, else → DONE.
  - WR1: same as WR0 for word1/buf1 with the overflow bytes. Next: → DONE.
  - DONE: LSUDone=1 and LSURData updated. Next: → IDLE.
- **Load result:** bytes are taken from {buf1, buf0} starting at off. LB/LH sign-extend; LBU/LHU zero-extend. Stores leave LSURData unchanged.
- **Idle bus:** outside RD/WR states, RAMAddr=0, RAMDataIn=0, RAMWriteControl=0.
- **Intra-word misalignment:** a misaligned access that does not cross (e.g. LH at off 1) completes normally.
- **Protected region:** writes to RAM words 0–1 are performed on the bus. The RAM drops them; the LSU does not check for this.

## Timing
- **Reset:** the reset cycle forces IDLE and clears LSUDone, LSUFault, LSURData, buf0, buf1 and the RAM outputs to 0. LSUReady=1 the cycle after reset.
- **Reset mid-operation:** aborts immediately, with RAMWriteControl=0 that cycle. If WR0 already completed, the first half of a split store stays written.
- **Latency** (accept edge → cycle with LSUDone):
  - aligned load: 2
  - sub-word store: 3
  - aligned SW: 2
  - crossing load: 3
  - crossing store: 5
  - fault: 1
- **Throughput:** LSUReady returns 1 the cycle after DONE, so back-to-back accepts are spaced by latency+1.
- **Read sampling:** RAMOut is sampled at the end of RD0/RD1, because the RAM read is zero-delay.
- **Write timing:** writes commit at the end of WR0/WR1.

## Configuration
- **MISALIGNED_SPLIT_EN defined:** crossing accesses use the RD1/WR1 split path.
- **MISALIGNED_SPLIT_EN undefined:**
  - Any cross access goes IDLE → DONE with LSUFault=1, no RAM access, and LSURData=0.
  - RD1 and WR1 are not built.
  - Non-crossing misaligned accesses still complete.

## Test plan
Preload RAM word 0x100=0x8899AABB and word 0x104=0x11223344.
- Reset, then idle: LSUReady=1, LSUDone=0, RAMWriteControl=0, LSURData=0.
- LB 0x101 → LSURData=0xFFFFFFAA, done 2 cycles after accept. LBU 0x103 → 0x00000088. LHU 0x102 → 0x00008899.
- SB 0x102 with data 0x00000055 → exactly one RAM write; word 0x100=0x8855AABB, done at cycle 3. SW 0x100 with 0xCAFEF00D → no read cycle, done at cycle 2.
- With the macro:
  - LW 0x102 → 0x33448899, done at cycle 3.
  - SW 0x103 with 0xDEADBEEF → 0x100=0xEF99AABB and 0x104=0x11DEADBE, done at cycle 5.
- Without the macro: LW 0x102 → LSUFault=1, LSURData=0, done at cycle 1, RAM unchanged. Funct3=011 load → fault in both builds.
- Assert reset during WR0 of a crossing SW: no write that cycle, IDLE afterwards, word 0x104 unchanged. A request held high during busy is accepted only once.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores mapped onto a zero-delay word RAM.
// Sub-word stores use read-modify-write. Define MISALIGNED_SPLIT_EN to split word-crossing
// accesses into two word accesses; without it they complete immediately with LSUFault=1.
module load_store_unit #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   LSUReq,
    input  logic                   LSUWrite,
    input  logic [2:0]             LSUFunct3,
    input  logic [RAMAddrSize-1:0] LSUAddr,
    input  logic [dataW-1:0]       LSUWData,
    output logic                   LSUReady,
    output logic                   LSUDone,
    output logic                   LSUFault,
    output logic [dataW-1:0]       LSURData,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);
`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;
    localparam bit split = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, RD0, WR0, DONE} state_t;
    localparam bit split = 1'b0;
`endif

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [2:0] f3);
        return ({1'b0, off} + size_of(f3)) > 3'd4;
    endfunction

    function automatic logic invalid(input logic wr, input logic [2:0] f3);
        return wr ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction

    state_t                 state;
    logic [RAMAddrSize-1:0] addr_q, word0, req_word0;
    logic [dataW-1:0]       wdata_q, buf0, lo, shifted, load_res;
    logic [2:0]             f3_q;
    logic                   write_q, we, req_fault, req_sw;
    logic [2*dataW-1:0]     cur, mask, merged;
    logic [4:0]             off_sh;
    logic [5:0]             size_sh;

    assign req_fault = invalid(LSUWrite, LSUFunct3) || (!split && crosses(LSUAddr[1:0], LSUFunct3));
    assign req_sw    = LSUWrite && LSUFunct3 == 3'b010 && LSUAddr[1:0] == 2'b00;
    assign req_word0 = {LSUAddr[RAMAddrSize-1:2], 2'b00};
    assign word0     = {addr_q[RAMAddrSize-1:2], 2'b00};
    assign lo        = (state == RD0) ? RAMOut : buf0;

`ifdef MISALIGNED_SPLIT_EN
    logic [dataW-1:0]       buf1;
    logic [RAMAddrSize-1:0] word1;
    logic                   cross_q;
    assign word1 = word0 + RAMAddrSize'(4);
    assign cur   = {(state == RD1) ? RAMOut : buf1, lo};
`else
    assign cur   = {{dataW{1'b0}}, lo};
`endif

    assign off_sh   = {addr_q[1:0], 3'b000};
    assign size_sh  = {size_of(f3_q), 3'b000};
    assign mask     = ~({(2*dataW){1'b1}} << size_sh) << off_sh;
    assign merged   = (cur & ~mask) | (({{dataW{1'b0}}, wdata_q} << off_sh) & mask);
    assign shifted  = dataW'(cur >> off_sh);
    assign load_res = f3_q[1] ? shifted :
                      f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                                {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    assign RAMWriteControl = we & ~reset;

    // Request capture, state sequencing and the registered RAM/LSU outputs for the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            LSUReady  <= 1'b1;
            LSUDone   <= 1'b0;
            LSUFault  <= 1'b0;
            LSURData  <= '0;
            RAMAddr   <= '0;
            RAMDataIn <= '0;
            we        <= 1'b0;
            buf0      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            write_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            buf1      <= '0;
            cross_q   <= 1'b0;
`endif
        end else begin
            LSUReady  <= 1'b0;
            LSUDone   <= 1'b0;
            RAMAddr   <= '0;
            RAMDataIn <= '0;
            we        <= 1'b0;
            case (state)
                IDLE: begin
                    LSUReady <= !LSUReq;
                    if (LSUReq) begin
                        addr_q   <= LSUAddr;
                        wdata_q  <= LSUWData;
                        f3_q     <= LSUFunct3;
                        write_q  <= LSUWrite;
                        LSUFault <= req_fault;
`ifdef MISALIGNED_SPLIT_EN
                        cross_q  <= crosses(LSUAddr[1:0], LSUFunct3);
`endif
                        if (req_fault) begin
                            state    <= DONE;
                            LSUDone  <= 1'b1;
                            LSURData <= '0;
                        end else if (req_sw) begin
                            state     <= WR0;
                            RAMAddr   <= req_word0;
                            RAMDataIn <= LSUWData;
                            we        <= 1'b1;
                        end else begin
                            state   <= RD0;
                            RAMAddr <= req_word0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= RAMOut;
`ifdef MISALIGNED_SPLIT_EN
                    if (cross_q) begin
                        state   <= RD1;
                        RAMAddr <= word1;
                    end else
`endif
                    if (write_q) begin
                        state     <= WR0;
                        RAMAddr   <= word0;
                        RAMDataIn <= dataW'(merged);
                        we        <= 1'b1;
                    end else begin
                        state    <= DONE;
                        LSUDone  <= 1'b1;
                        LSURData <= load_res;
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                RD1: begin
                    buf1 <= RAMOut;
                    if (write_q) begin
                        state     <= WR0;
                        RAMAddr   <= word0;
                        RAMDataIn <= dataW'(merged);
                        we        <= 1'b1;
                    end else begin
                        state    <= DONE;
                        LSUDone  <= 1'b1;
                        LSURData <= load_res;
                    end
                end
                WR1: begin
                    state   <= DONE;
                    LSUDone <= 1'b1;
                end
`endif
                WR0: begin
`ifdef MISALIGNED_SPLIT_EN
                    if (cross_q) begin
                        state     <= WR1;
                        RAMAddr   <= word1;
                        RAMDataIn <= dataW'(merged >> dataW);
                        we        <= 1'b1;
                    end else
`endif
                    begin
                        state   <= DONE;
                        LSUDone <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    LSUReady <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit split = 1'b1;
`else
    localparam bit split = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1;
    logic        LSUReq = 1'b0, LSUWrite = 1'b0;
    logic [2:0]  LSUFunct3 = 3'd0;
    logic [31:0] LSUAddr = 32'd0, LSUWData = 32'd0;
    logic        LSUReady, LSUDone, LSUFault, RAMWriteControl;
    logic [31:0] LSURData, RAMAddr, RAMDataIn, RAMOut;

    load_store_unit #(.dataW(32), .RAMAddrSize(32)) dut (
        .clock(clock), .reset(reset), .LSUReq(LSUReq), .LSUWrite(LSUWrite),
        .LSUFunct3(LSUFunct3), .LSUAddr(LSUAddr), .LSUWData(LSUWData),
        .LSUReady(LSUReady), .LSUDone(LSUDone), .LSUFault(LSUFault), .LSURData(LSURData),
        .RAMAddr(RAMAddr), .RAMDataIn(RAMDataIn), .RAMWriteControl(RAMWriteControl), .RAMOut(RAMOut)
    );

    always #5 clock = ~clock;

    // Zero-delay RAM; words 0 and 1 silently drop writes.
    logic [31:0] ram [0:255];
    int          wr_total = 0, cyc = 0;
    assign RAMOut = ram[RAMAddr[9:2]];
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (RAMWriteControl) begin
            wr_total <= wr_total + 1;
            if (RAMAddr[31:3] != 29'd0) ram[RAMAddr[9:2]] <= RAMDataIn;
        end
    end

    // Reference model: plain byte memory plus the last load result.
    logic [7:0]  mb [0:1023];
    logic [31:0] last_rd = 32'd0;
    typedef struct {logic fault; logic [31:0] rd; int due; int wr0; int wrs;} exp_t;
    exp_t q[$];
    exp_t me;
    int   total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] w);
        return {mb[{w[9:2], 2'd3}], mb[{w[9:2], 2'd2}], mb[{w[9:2], 2'd1}], mb[{w[9:2], 2'd0}]};
    endfunction

    // Monitor: pops the scoreboard on every completion and watches the bus.
    always @(negedge clock) begin
        if (!reset) begin
            check("ram_addr_align", {30'd0, RAMAddr[1:0]}, 32'd0);
            if (LSUReady) check("idle_bus", RAMAddr | RAMDataIn | {31'd0, RAMWriteControl}, 32'd0);
            if (LSUDone) begin
                if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    me = q.pop_front();
                    check("fault", {31'd0, LSUFault}, {31'd0, me.fault});
                    check("rdata", LSURData, me.rd);
                    check("latency", 32'(cyc), 32'(me.due));
                    check("ram_writes", 32'(wr_total - me.wr0), 32'(me.wrs));
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit hold_max);
        int sz, lat, nw, k, t;
        logic flt, cr;
        logic [31:0] v, b, w0;
        t = 0;
        while (!LSUReady && t < 40) begin @(negedge clock); t++; end
        check("ready_before_issue", {31'd0, LSUReady}, 32'd1);
        sz  = f3[1] ? 4 : f3[0] ? 2 : 1;
        cr  = (int'(a[1:0]) + sz) > 4;
        flt = (wr ? f3 > 3'd2 : (f3 == 3'd3 || f3 >= 3'd6)) || (cr && !split);
        v = 32'd0;
        nw = 0;
        if (flt) lat = 1;
        else if (wr) begin
            lat = (sz == 4 && a[1:0] == 2'd0) ? 2 : cr ? 5 : 3;
            nw  = cr ? 2 : 1;
            for (int i = 0; i < sz; i++) begin
                b = a + 32'(i);
                if (b >= 32'd8) mb[b[9:0]] = d[8*i +: 8];
            end
            v = last_rd;
        end else begin
            lat = cr ? 3 : 2;
            for (int i = 0; i < sz; i++) begin
                b = a + 32'(i);
                v[8*i +: 8] = mb[b[9:0]];
            end
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        end
        last_rd = v;
        LSUWrite = wr; LSUFunct3 = f3; LSUAddr = a; LSUWData = d; LSUReq = 1'b1;
        q.push_back('{flt, v, cyc + lat, wr_total, nw});
        k = hold_max ? lat : $urandom_range(0, lat);
        repeat (k + 1) @(negedge clock);
        LSUReq = 1'b0; LSUAddr = $urandom; LSUWData = $urandom; LSUFunct3 = 3'($urandom);
        t = 0;
        while (!LSUReady && t < 40) begin @(negedge clock); t++; end
        check("ready_after_done", {31'd0, LSUReady}, 32'd1);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        q.delete();
        w0 = a & ~32'd3;
        check("ram_word0", ram[w0[9:2]], mword(w0));
        w0 = w0 + 32'd4;
        check("ram_word1", ram[w0[9:2]], mword(w0));
    endtask

    task automatic reset_mid_store();
        int t;
        t = 0;
        LSUWrite = 1'b1; LSUFunct3 = split ? 3'd2 : 3'd0;
        LSUAddr = split ? 32'h103 : 32'h102; LSUWData = 32'h5A5A_5A5A; LSUReq = 1'b1;
        @(negedge clock);
        LSUReq = 1'b0;
        while (!RAMWriteControl && t < 10) begin @(negedge clock); t++; end
        check("reached_wr0", {31'd0, RAMWriteControl}, 32'd1);
        reset = 1'b1;
        #1;
        check("no_write_in_reset", {31'd0, RAMWriteControl}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        last_rd = 32'd0;
        check("rst_ready", {31'd0, LSUReady}, 32'd1);
        check("rst_done", {31'd0, LSUDone}, 32'd0);
        check("rst_rdata", LSURData, 32'd0);
        check("rst_word_100", ram[8'h40], mword(32'h100));
        check("rst_word_104", ram[8'h41], mword(32'h104));
    endtask

    logic [2:0] f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};

    initial begin
        logic [31:0] v;
        logic [2:0]  f3;
        for (int i = 0; i < 256; i++) begin
            v = (i == 8'h40) ? 32'h8899_AABB : (i == 8'h41) ? 32'h1122_3344 : $urandom;
            ram[i] <= v;
            for (int j = 0; j < 4; j++) mb[4*i + j] = v[8*j +: 8];
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", {31'd0, LSUReady}, 32'd1);
        check("reset_done", {31'd0, LSUDone}, 32'd0);
        check("reset_we", {31'd0, RAMWriteControl}, 32'd0);
        check("reset_rdata", LSURData, 32'd0);
        check("reset_fault", {31'd0, LSUFault}, 32'd0);

        issue(1'b0, 3'd0, 32'h101, 32'd0, 1'b1);
        check("lb_101", LSURData, 32'hFFFF_FFAA);
        issue(1'b0, 3'd4, 32'h103, 32'd0, 1'b1);
        check("lbu_103", LSURData, 32'h0000_0088);
        issue(1'b0, 3'd5, 32'h102, 32'd0, 1'b1);
        check("lhu_102", LSURData, 32'h0000_8899);
        issue(1'b0, 3'd2, 32'h102, 32'd0, 1'b1);
        check("lw_102", LSURData, split ? 32'h3344_8899 : 32'h0);
        issue(1'b1, 3'd2, 32'h103, 32'hDEAD_BEEF, 1'b1);
        check("sw_103_w0", ram[8'h40], split ? 32'hEF99_AABB : 32'h8899_AABB);
        check("sw_103_w1", ram[8'h41], split ? 32'h11DE_ADBE : 32'h1122_3344);
        issue(1'b1, 3'd0, 32'h102, 32'h0000_0055, 1'b1);
        check("sb_102", ram[8'h40], split ? 32'hEF55_AABB : 32'h8855_AABB);
        issue(1'b1, 3'd2, 32'h100, 32'hCAFE_F00D, 1'b1);
        issue(1'b0, 3'd3, 32'h100, 32'd0, 1'b1);
        issue(1'b1, 3'd3, 32'h100, 32'h1234_5678, 1'b0);
        issue(1'b0, 3'd6, 32'h104, 32'd0, 1'b0);
        issue(1'b0, 3'd1, 32'h101, 32'd0, 1'b0);
        issue(1'b0, 3'd1, 32'h103, 32'd0, 1'b0);
        issue(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, 1'b0);
        issue(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b0);
        issue(1'b1, 3'd2, 32'h0000_0004, 32'h7777_7777, 1'b0);
        issue(1'b0, 3'd2, 32'h0000_0004, 32'd0, 1'b0);
        reset_mid_store();

        for (int n = 0; n < 300; n++) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 7)];
            issue(1'($urandom_range(0, 1)), f3, 32'h100 + 32'($urandom_range(0, 255)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        for (int i = 0; i < 256; i++) check("final_ram", ram[i], mword(32'(4*i)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
